// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//
// Reads a block of consecutive words from a synchronous-read RAM and
// presents them one at a time on a valid/ready stream. Each word takes a
// READ cycle (address presented), a CAPTURE cycle (RAM data arrives and is
// registered), and then sits in SEND until the consumer accepts it.
// Addresses wrap modulo the RAM depth.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle sweep request, only looked at while idle
//   base_addr  : first RAM address of the sweep (latched on accept)
//   length     : number of words, 0 .. 2**ADDR_WIDTH (latched on accept)
//   ram_r_en   : RAM read enable, high only in READ
//   ram_addr   : RAM read address, held between reads
//   ram_data   : RAM read data, valid the cycle after ram_r_en
//   out_data   : stream word
//   out_valid  : out_data holds a word
//   out_ready  : consumer accepts the word when out_valid is also high
//   busy       : high whenever not idle
//   done       : one-cycle pulse when a sweep completes
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   length_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;

    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  handshake;
    logic                  last_word;

    // Natural wrap of the address width gives the modulo-depth wrap.
    assign addr_inc  = addr_reg + 1'b1;
    assign count_inc = count_reg + 1'b1;
    assign handshake = (state_reg == S_SEND) && out_ready;
    assign last_word = (count_inc == length_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? S_READ : S_FINISH;
                end
            end
            S_READ:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_SEND;
            S_SEND: begin
                if (out_ready) begin
                    state_next = last_word ? S_FINISH : S_READ;
                end
            end
            S_FINISH:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            ram_addr_reg  <= '0;
            count_reg     <= '0;
            length_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Sweep parameters are captured only here, so later changes on
            // base_addr/length (or extra start pulses) cannot disturb a sweep.
            if (state_reg == S_IDLE && start && length != '0) begin
                addr_reg     <= base_addr;
                ram_addr_reg <= base_addr;
                length_reg   <= length;
                count_reg    <= '0;
            end

            if (state_reg == S_CAPTURE) begin
                out_data_reg  <= ram_data;
                out_valid_reg <= 1'b1;
            end

            if (handshake) begin
                out_valid_reg <= 1'b0;
                count_reg     <= count_inc;
                addr_reg      <= addr_inc;
                // The RAM address register only moves on the way into READ,
                // so it holds steady in every other state.
                if (!last_word) begin
                    ram_addr_reg <= addr_inc;
                end
            end
        end
    end

    assign ram_r_en  = (state_reg == S_READ);
    assign ram_addr  = ram_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_FINISH);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a RAM model where mem[i] = i[7:0].
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          ram_r_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .ram_r_en  (ram_r_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model: contents are the low byte of the address.
    always @(posedge clk) begin
        if (ram_r_en) ram_data <= ram_addr[7:0];
    end

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] w_data[$];
    int            w_cyc[$];
    logic [AW-1:0] r_addr[$];
    int            done_cnt;
    int            done_cyc;
    int            busy_cnt;
    int            valid_cnt;
    int            stall_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep, sampling at negedges. Optionally stalls one word and
    // pulses start again part-way through. base_addr/length are scrambled
    // after acceptance to show they are not re-sampled.
    task automatic sweep(input logic [AW-1:0] b, input logic [AW:0] l,
                         input int stall_idx, input int stall_len,
                         input int restart_cyc, input int max_cyc);
        int            cyc;
        logic [AW-1:0] a;
        w_data.delete();
        w_cyc.delete();
        r_addr.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        busy_cnt   = 0;
        valid_cnt  = 0;
        stall_left = stall_len;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l; out_ready = 1'b1;
        cyc = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            start     = (cyc == restart_cyc);
            base_addr = ~b;
            length    = l + 13'd3;
            if (busy) busy_cnt++;
            if (ram_r_en) r_addr.push_back(ram_addr);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid) begin
                valid_cnt++;
                a = b + AW'(w_data.size());
                if (w_data.size() == stall_idx && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check("stall_data", out_data, a[7:0]);
                    check("stall_ren", ram_r_en, 0);
                end else begin
                    out_ready = 1'b1;
                    w_data.push_back(out_data);
                    w_cyc.push_back(cyc);
                end
            end else begin
                out_ready = cyc[0];
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        check("sweep_completed", 32'(done_cnt != 0), 1);
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_words(input string tag, input logic [AW-1:0] b, input logic [AW:0] l,
                               input int stall_idx, input int stall_len);
        logic [AW-1:0] a;
        int            n;
        int            exp_cyc;
        int            bad_d;
        int            bad_a;
        int            bad_c;
        n = int'(l);
        check({tag, "_words"}, w_data.size(), n);
        check({tag, "_reads"}, r_addr.size(), n);
        check({tag, "_valid_cycles"}, valid_cnt, n + stall_len);
        bad_d = 0; bad_a = 0; bad_c = 0;
        if (w_data.size() == n && r_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                a = b + AW'(i);
                exp_cyc = 3 + 3 * i + ((i >= stall_idx) ? stall_len : 0);
                if (w_data[i] !== a[7:0]) bad_d++;
                if (r_addr[i] !== a) bad_a++;
                if (w_cyc[i] != exp_cyc) bad_c++;
                if (n <= 8) begin
                    check({tag, "_data"}, w_data[i], a[7:0]);
                    check({tag, "_addr"}, r_addr[i], a);
                    check({tag, "_word_cycle"}, w_cyc[i], exp_cyc);
                end
            end
            if (n > 8) begin
                check({tag, "_bad_data"}, bad_d, 0);
                check({tag, "_bad_addr"}, bad_a, 0);
                check({tag, "_bad_cycle"}, bad_c, 0);
            end
        end
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, 3 * n + stall_len + 1);
        check({tag, "_busy_cycles"}, busy_cnt, 3 * n + stall_len + 1);
        check({tag, "_busy_after"}, busy, 0);
        $display("sweep %s base=0x%03h len=%0d: words=%0d done_cyc=%0d", tag, b, l, w_data.size(), done_cyc);
    endtask

    initial begin
        int seen;
        int aborted_done;
        bit visited[4096];
        int miss;

        // Asynchronous reset with no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("rst_ren", ram_r_en, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Basic sweep, full-rate consumer.
        sweep(12'h010, 13'd4, -1, 0, -1, 60);
        check_words("basic", 12'h010, 13'd4, -1, 0);

        // Address wrap past the top of the RAM.
        sweep(12'hFFE, 13'd4, -1, 0, -1, 60);
        check_words("wrap", 12'hFFE, 13'd4, -1, 0);

        // Consumer stalls 5 cycles on the second word.
        sweep(12'h020, 13'd4, 1, 5, -1, 60);
        check_words("stall", 12'h020, 13'd4, 1, 5);

        // Zero-length sweep: straight to FINISH.
        sweep(12'h040, 13'd0, -1, 0, -1, 20);
        check_words("len0", 12'h040, 13'd0, -1, 0);

        // Extra start while busy is ignored.
        sweep(12'h030, 13'd8, -1, 0, 5, 60);
        check_words("restart", 12'h030, 13'd8, -1, 0);

        // Full-depth sweep touches every location once.
        sweep(12'h800, 13'd4096, -1, 0, -1, 3 * 4096 + 20);
        check_words("full", 12'h800, 13'd4096, -1, 0);
        foreach (visited[i]) visited[i] = 1'b0;
        foreach (r_addr[i]) visited[r_addr[i]] = 1'b1;
        miss = 0;
        foreach (visited[i]) if (!visited[i]) miss++;
        check("full_unvisited", miss, 0);

        // Reset while the third word waits in SEND.
        @(negedge clk);
        start = 1'b1; base_addr = 12'h000; length = 13'd8; out_ready = 1'b1;
        seen = 0;
        aborted_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) aborted_done++;
            if (out_valid) begin
                seen++;
                if (seen == 3) begin
                    out_ready = 1'b0;
                    break;
                end
            end
        end
        check("abort_word3_reached", seen, 3);
        check("abort_word3_data", out_data, 8'h02);
        #2 rst = 1'b1;
        #1;
        check("abort_ren", ram_r_en, 0);
        check("abort_addr", ram_addr, 0);
        check("abort_data", out_data, 0);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) aborted_done++;
        end
        check("abort_no_done_idle", aborted_done, 0);
        $display("abort: reset taken in SEND after word 3");

        sweep(12'h100, 13'd2, -1, 0, -1, 40);
        check_words("after_abort", 12'h100, 13'd2, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
